// File: rtl/ps2_key_framer.sv
// PS/2 keyboard receiver: deserialises 11-bit frames and groups prefix bytes into 65-bit key events.
// Optional stability filter on both lines when PS2_KEY_GLITCH_FILTER_EN is defined.
module ps2_key_framer #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 24000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ps2_clk_in,
   input  logic        ps2_dat_in,
   output logic [64:0] ps2_key,
   output logic        byte_valid,
   output logic [7:0]  byte_out,
   output logic        frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t      state;
   logic [1:0]  clk_sync;
   logic [1:0]  dat_sync;
   logic        clk_filt;
   logic        dat_filt;
   logic        clk_prev;
   logic        clk_fall;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic        start_bit;
   logic        par_bit;
   logic [TW-1:0] tcnt;
   logic [63:0] hist;
   logic [2:0]  e1cnt;
   logic [63:0] hist_new;
   logic [2:0]  e1_new;
   logic        ev_done;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk_in};
         dat_sync <= {dat_sync[0], ps2_dat_in};
      end
   end

`ifdef PS2_KEY_GLITCH_FILTER_EN
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam logic [FW-1:0] FLIM = FW'(FILTER_LEN - 1);

   logic [FW-1:0] clk_cnt;
   logic [FW-1:0] dat_cnt;

   // A filtered level only follows the synchroniser after FILTER_LEN disagreeing samples in a row.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_filt <= 1'b1;
         dat_filt <= 1'b1;
         clk_cnt  <= '0;
         dat_cnt  <= '0;
      end else begin
         if (clk_sync[1] == clk_filt) begin
            clk_cnt <= '0;
         end else if (clk_cnt == FLIM) begin
            clk_filt <= clk_sync[1];
            clk_cnt  <= '0;
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end
         if (dat_sync[1] == dat_filt) begin
            dat_cnt <= '0;
         end else if (dat_cnt == FLIM) begin
            dat_filt <= dat_sync[1];
            dat_cnt  <= '0;
         end else begin
            dat_cnt <= dat_cnt + 1'b1;
         end
      end
   end
`else
   localparam int unused_filter_len = FILTER_LEN;

   assign clk_filt = clk_sync[1];
   assign dat_filt = dat_sync[1];
`endif

   assign clk_fall = clk_prev & ~clk_filt;

   // Next assembler state for the byte currently held in shreg; hist is already zero at event start.
   always_comb begin
      hist_new = {hist[55:0], shreg};
      e1_new   = e1cnt;
      ev_done  = 1'b0;
      if (e1cnt != 3'd0) begin
         e1_new  = e1cnt - 3'd1;
         ev_done = (e1cnt == 3'd1);
      end else if (shreg == 8'hE1) begin
         e1_new = 3'd7;
      end else if (shreg != 8'hE0 && shreg != 8'hF0) begin
         ev_done = 1'b1;
      end
   end

   // The start bit is latched on the first fall and judged on the second, which also carries data bit 0.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         clk_prev   <= 1'b1;
         bit_cnt    <= 3'd0;
         shreg      <= 8'h00;
         start_bit  <= 1'b0;
         par_bit    <= 1'b0;
         tcnt       <= '0;
         hist       <= 64'h0;
         e1cnt      <= 3'd0;
         ps2_key    <= 65'h0;
         byte_valid <= 1'b0;
         byte_out   <= 8'h00;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         clk_prev   <= clk_filt;
         if (state != IDLE && tcnt == TLIM) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            tcnt      <= '0;
            hist      <= 64'h0;
            e1cnt     <= 3'd0;
         end else begin
            if (state == IDLE || clk_fall) begin
               tcnt <= '0;
            end else if (tcnt != TLIM) begin
               tcnt <= tcnt + 1'b1;
            end
            if (clk_fall) begin
               case (state)
                  IDLE: begin
                     start_bit <= dat_filt;
                     state     <= START;
                  end
                  START: begin
                     if (start_bit) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        hist      <= 64'h0;
                        e1cnt     <= 3'd0;
                     end else begin
                        shreg   <= {dat_filt, shreg[7:1]};
                        bit_cnt <= 3'd1;
                        state   <= DATA;
                     end
                  end
                  DATA: begin
                     shreg   <= {dat_filt, shreg[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state <= PARITY;
                     end
                  end
                  PARITY: begin
                     par_bit <= dat_filt;
                     state   <= STOP;
                  end
                  STOP: begin
                     state <= IDLE;
                     if (dat_filt && (^{shreg, par_bit})) begin
                        byte_valid <= 1'b1;
                        byte_out   <= shreg;
                        e1cnt      <= e1_new;
                        if (ev_done) begin
                           hist    <= 64'h0;
                           ps2_key <= {~ps2_key[64], hist_new};
                        end else begin
                           hist <= hist_new;
                        end
                     end else begin
                        frame_err <= 1'b1;
                        hist      <= 64'h0;
                        e1cnt     <= 3'd0;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: doc/ps2_key_framer.md
# ps2_key_framer

Receives the raw PS/2 keyboard line pair, deserialises 11-bit frames into scancode bytes, and groups prefix sequences (E0, F0, E1) into complete key events. Each event is published as the 65-bit `ps2_key` word with a toggling strobe bit, the same format the core's keyboard decoder consumes. The block lets a core accept a physical PS/2 keyboard on user I/O in place of, or alongside, the HPS-supplied event word.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical samples needed before a filtered line level changes.
- TIMEOUT_CYC, 24000: idle cycles mid-frame before the frame is aborted (2 ms at 12 MHz).

Ports:
- clk_sys  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk_in  in  1  raw PS/2 clock line, asynchronous.
- ps2_dat_in  in  1  raw PS/2 data line, asynchronous.
- ps2_key  out  65  [64] event toggle; [63:0] byte history, newest byte in [7:0].
- byte_valid  out  1  one-cycle pulse per correctly received byte.
- byte_out  out  8  last received byte; valid while byte_valid is high, held afterwards.
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error.

## Operation
- Input conditioning: 2-flop synchroniser on each line, then the optional filter (see Configuration). A falling edge of filtered clk marks a data sample point.
- Bit FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a clk falling edge.
  - START: data must be 0, else frame_err and return to IDLE. On 0 go to DATA.
  - DATA: 8 bits, LSB first, using a 3-bit counter. Go to PARITY after bit 7.
  - PARITY: records the sampled bit.
  - STOP: data must be 1, and the XOR of the 8 data bits plus parity must be 1 (odd parity). If both hold, pulse byte_valid and go to IDLE. Otherwise pulse frame_err and go to IDLE.
- Timeout: a counter clears on every clk falling edge. If it reaches TIMEOUT_CYC in any state except IDLE, pulse frame_err and go to IDLE.
- Any frame_err also clears the sequence assembler.
- Sequence assembler: a 64-bit history register `hist` and a 3-bit E1 countdown `e1cnt`. On each valid byte:
  - If the byte starts a new event (the previous event completed), hist is first cleared to 0.
  - hist <= {hist[55:0], byte}.
  - If e1cnt != 0: decrement. When it reaches 0 the event is complete.
  - Else if byte == E1: e1cnt <= 7 (Pause is 8 bytes in total).
  - Else if byte is E0 or F0: continue the event.
  - Else: the event is complete.
- Event complete: ps2_key[63:0] <= hist including this byte, and ps2_key[64] inverts. Both update in the same cycle.
- Resulting encodings:
  - Plain press: low byte only, e.g. 0x1C.
  - Release: F0 in [15:8].
  - Extended release: E0 in [23:16], F0 in [15:8].
  - Pause: the full 8 bytes, so [63:24] is nonzero.
  - Print Screen (E0 12 E0 7C) is emitted as two events, E0 12 and E0 7C. This is accepted behaviour.
- Device-to-host only. The block never drives either PS/2 line.

## Timing
- Reset values: ps2_key = 0, byte_out = 0, byte_valid = 0, frame_err = 0. FSM in IDLE, hist = 0, e1cnt = 0, timeout counter = 0.
- Reset asserted mid-frame or mid-sequence discards all partial state. No event toggle is produced.
- Latency from a line falling edge to the sample point: 2 cycles (synchroniser), plus FILTER_LEN cycles when the filter is compiled in.
- byte_valid is asserted 1 cycle after the STOP sample point.
- ps2_key updates in the same cycle as the byte_valid that completes the event. The toggle flips exactly once per event.
- byte_valid and frame_err are never high in the same cycle.
- The timeout counter saturates at TIMEOUT_CYC and does not wrap.
- Minimum PS/2 bit period is 60 µs, which is at least 720 cycles at 12 MHz. No back-pressure: events are overwritten, and the consumer must sample within one event period.

## Configuration
- PS2_KEY_GLITCH_FILTER_EN defined:
  - Each synchronised line passes a FILTER_LEN-sample stability filter.
  - Pulses shorter than FILTER_LEN cycles are ignored.
- Undefined:
  - The filtered level equals the synchroniser output.
  - Sample latency is 2 cycles.
  - FILTER_LEN is unused.

## Test plan
- Frame 0x1C with parity 0 -> one byte_valid with byte_out = 0x1C. ps2_key = {1'b1, 64'h1C}.
- Sequence E0 F0 75 -> three byte_valid pulses and one toggle only. ps2_key[63:0] = 0xE0F075.
- Byte 0x29 sent with wrong parity -> frame_err pulse and no byte_valid. ps2_key is unchanged. The following good F0 29 produces an event of exactly 0xF029.
- Clock held high after data bit 3 for TIMEOUT_CYC + 10 cycles -> frame_err exactly once. The next full frame is received correctly.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> one event with ps2_key[63:0] = 0xE11477E1F014F077.
- With the filter compiled in, a 3-cycle low glitch on the clock line in IDLE -> no state change. With the filter compiled out, the same glitch produces frame_err after the timeout.
